// File: rtl/tpu_readback_pkg.sv
// Shared types and default sizes for the UB readback streamer.
// The optional checksum byte is enabled by defining READBACK_CSUM_EN.
package tpu_readback_pkg;

  localparam int DATA_W_DEF    = 256;
  localparam int ADDR_W_DEF    = 8;
  localparam int CNT_W_DEF     = 9;
  localparam int UB_RD_LAT_DEF = 1;
  localparam int BYTES_PER_ROW = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND,
    S_CSUM,
    S_FINISH
  } state_e;

endpackage

// File: rtl/ub_readback_streamer_row_serializer.sv
// Row shift register: loads one UB row, emits it LSB byte first, flags the last byte.
module row_serializer
  import tpu_readback_pkg::*;
#(
  parameter int BPR = BYTES_PER_ROW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [BPR*8-1:0] data_i,
  input  logic             shift_i,
  output logic [7:0]       byte_o,
  output logic             last_o
);

  localparam int DATA_W = BPR * 8;
  localparam int IDX_W  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPR - 1);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    if (load_i) begin
      sreg_d = data_i;
      idx_d  = '0;
    end else if (shift_i) begin
      sreg_d = sreg_q >> 8;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  // NOTE: the row register is a plain flop bank, not a RAM, so it is safe to reset it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
    end
  end

  assign byte_o = sreg_q[7:0];
  assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/ub_readback_streamer.sv
// Streams a run of Unified Buffer rows to the UART TX byte interface, byte 0 first.
// Define READBACK_CSUM_EN to append a modulo-256 checksum byte after the last row.
module ub_readback_streamer
  import tpu_readback_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int UB_RD_LAT = UB_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  row_count,
  output logic              busy,
  output logic              done,
  output logic              ub_rd_en,
  output logic [ADDR_W-1:0] ub_rd_addr,
  input  logic [DATA_W-1:0] ub_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [15:0]       bytes_sent
);

  localparam int LAT_W = $clog2(UB_RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(UB_RD_LAT);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rows_left_q;
  logic [LAT_W-1:0]  wait_q;
  logic              busy_q, done_q, rd_en_q, tx_valid_q;
  logic [15:0]       bytes_q;

  logic              accept, ser_load, ser_shift, ser_last;
  logic [DATA_W-1:0] ser_data;
  logic [7:0]        ser_byte;

  assign accept    = tx_valid_q && tx_ready;
  assign ser_shift = accept && (state_q == S_SEND);

`ifdef READBACK_CSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  // The checksum byte is sent by loading it into the serializer like a one-byte row.
  always_comb begin
    ser_load = (state_q == S_RD_WAIT) && (wait_q == LAT_LAST);
    ser_data = ub_rd_data;
`ifdef READBACK_CSUM_EN
    csum_d = csum_q;
    if (state_q == S_IDLE && start) csum_d = '0;
    else if (ser_shift)             csum_d = csum_q + ser_byte;
    if ((state_q == S_IDLE && start && row_count == '0) ||
        (ser_shift && ser_last && rows_left_q <= CNT_W'(1))) begin
      ser_load = 1'b1;
      ser_data = DATA_W'(csum_d);
    end
`endif
  end

  row_serializer #(.BPR(DATA_W / 8)) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .data_i  (ser_data),
    .shift_i (ser_shift),
    .byte_o  (ser_byte),
    .last_o  (ser_last)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rows_left_q <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      bytes_q     <= '0;
`ifdef READBACK_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (accept) bytes_q <= bytes_q + 16'd1;
`ifdef READBACK_CSUM_EN
      csum_q <= csum_d;
`endif
      unique case (state_q)
        S_IDLE: if (start) begin
          addr_q      <= start_addr;
          rows_left_q <= row_count;
          bytes_q     <= '0;
          if (row_count == '0) begin
`ifdef READBACK_CSUM_EN
            state_q    <= S_CSUM;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
`else
            state_q <= S_FINISH;
`endif
          end else begin
            state_q <= S_RD_REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_RD_REQ: begin
          state_q <= S_RD_WAIT;
          wait_q  <= '0;
        end
        // One cycle beyond the nominal latency so the read data has a full cycle to settle.
        S_RD_WAIT: begin
          if (wait_q == LAT_LAST) begin
            state_q    <= S_SEND;
            tx_valid_q <= 1'b1;
          end else begin
            wait_q <= wait_q + LAT_W'(1);
          end
        end
        S_SEND: if (accept && ser_last) begin
          if (rows_left_q > CNT_W'(1)) begin
            tx_valid_q  <= 1'b0;
            rows_left_q <= rows_left_q - CNT_W'(1);
            addr_q      <= addr_q + ADDR_W'(1);
            rd_en_q     <= 1'b1;
            state_q     <= S_RD_REQ;
          end else begin
`ifdef READBACK_CSUM_EN
            state_q <= S_CSUM;
`else
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_FINISH;
`endif
          end
        end
        S_CSUM: if (accept) begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_FINISH;
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ub_rd_en   = rd_en_q;
  assign ub_rd_addr = addr_q;
  assign tx_data    = ser_byte;
  assign tx_valid   = tx_valid_q;
  assign bytes_sent = bytes_q;

endmodule

// File: doc/ub_readback_streamer.md
Name: ub_readback_streamer

Overview:
- TPU→host readback engine for the UART DMA path.
- Reads a run of 256-bit Unified Buffer rows and serializes each row into 32 bytes.
- Presents the bytes to the UART transmitter over a valid/ready byte stream.
- Complements the host→TPU write path. Sits between the datapath UB read port and the UART TX byte interface.

Parameters:
- DATA_W, 256, UB row width in bits; must be a multiple of 8.
- ADDR_W, 8, UB row address width.
- CNT_W, 9, width of row_count; allows 0..256 rows.
- UB_RD_LAT, 1, UB read latency in cycles from ub_rd_en to valid ub_rd_data; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- start_addr  in  ADDR_W  first UB row
- row_count  in  CNT_W  number of rows to stream
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- ub_rd_en  out  1  UB read strobe
- ub_rd_addr  out  ADDR_W  UB read address
- ub_rd_data  in  DATA_W  UB read data
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX can accept a byte
- bytes_sent  out  16  running byte count for the current transfer (debug)

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, all outputs 0, internal counters and shift register cleared. Reset mid-transfer aborts immediately: no done pulse, tx_valid drops the next cycle.
- FSM states: IDLE, RD_REQ, RD_WAIT, SEND, CSUM, FINISH.
- IDLE:
  - start=1 latches start_addr and row_count, clears bytes_sent.
  - row_count==0 → FINISH.
  - Otherwise → RD_REQ.
- RD_REQ:
  - ub_rd_en=1 for exactly one cycle; ub_rd_addr = current address.
  - → RD_WAIT.
- RD_WAIT:
  - Waits UB_RD_LAT cycles, then captures ub_rd_data into a DATA_W shift register.
  - Byte index set to 0; → SEND.
- SEND:
  - tx_valid=1; tx_data = shift_reg[7:0]. Byte 0 (row bits 7:0) goes first, little-endian.
  - On tx_valid&&tx_ready: shift right 8, byte index+1, bytes_sent+1.
  - tx_data and tx_valid hold stable while tx_ready=0.
  - After byte DATA_W/8−1 is accepted:
    - If rows remain: address+1 modulo 2^ADDR_W (255 wraps to 0), remaining rows−1, → RD_REQ.
    - Otherwise → CSUM if the feature is enabled, else FINISH.
- FINISH: done=1 for one cycle, busy=0; → IDLE.
- Latency: with start sampled at edge T, first tx_valid rises at edge T+2+UB_RD_LAT. Each subsequent row costs 2+UB_RD_LAT dead cycles between its last and first bytes.
- ub_rd_en is never asserted outside RD_REQ. Only one read is outstanding at a time.
- start while busy is ignored, with no effect on the latched parameters.
- tx_ready high while tx_valid is low has no effect.
- bytes_sent wraps modulo 2^16.

Optional Feature:
- Macro: READBACK_CSUM_EN.
- Defined:
  - A running 8-bit modulo-256 sum of every byte accepted on the TX stream.
  - After the last row, the CSUM state sends the sum as one extra byte under the same valid/ready rules, then → FINISH.
  - For row_count==0 the checksum byte 0x00 is sent before done.
- Undefined: the CSUM state and the accumulator are absent; SEND goes directly to FINISH.

Decomposition:
- Shared package tpu_readback_pkg holds:
  - The FSM state enum.
  - BYTES_PER_ROW = DATA_W/8.
  - Default width constants.
- One sub-module, row_serializer: DATA_W load/shift register with byte index and last-byte flag.

Test Plan:
- start_addr=0x10, row_count=1, UB row 0x10 = bytes 0x00..0x1F, tx_ready=1 → 32 bytes 0x00..0x1F in order. First tx_valid 3 cycles after start; done 1 cycle after the 32nd byte; bytes_sent=32.
- tx_ready toggled 1-of-3 cycles during a 2-row transfer → no byte dropped or duplicated; tx_data stable while stalled; 64 bytes total.
- start_addr=0xFF, row_count=2 → ub_rd_addr sequence 0xFF then 0x00.
- row_count=0 → no ub_rd_en; done pulses 2 cycles after start; no TX bytes (without READBACK_CSUM_EN).
- rst_n low while sending byte 5 → tx_valid=0 next cycle, busy=0, no done. A following start re-streams from byte 0.
- READBACK_CSUM_EN defined, row of bytes 0x00..0x1F → 33rd byte = 0xF0 (sum 496 mod 256).
